// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// The glyph table is the active-low encoding the board firmware drives,
// so decoding is a reverse lookup into it.
package seg7_pkg;

   // Bus pattern with every segment off.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low glyphs, bit0=a .. bit6=g. Entry i is the pattern for nibble i.
   // The list reads from index 15 down to index 0.
   localparam logic [15:0][6:0] GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Per-digit capture FSM.
   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_PUBLISH = 2'd2
   } state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the display glyph table.
// hit is set only for one of the 16 hex glyphs; an all-off pattern reports
// blank instead. Anything that is neither a glyph nor blank returns
// nibble 0 with both flags low, and the caller flags it as an error.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pat,
   output logic       hit,
   output logic       blank,
   output logic [3:0] nibble
);

   // Reverse lookup. The glyphs are unique, so at most one entry matches.
   always_comb begin
      hit    = 1'b0;
      nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (pat == GLYPH[i]) begin
            hit    = 1'b1;
            nibble = 4'(i);
         end
      end
   end

   assign blank = (pat == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus and rebuilds the hex
// word on display. The datapath is:
//   input register -> stability filter -> per-digit capture FSM
//   -> frame publish.
// The publish stage emits one value_valid pulse each time every digit has
// been seen at least once.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    value_valid,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic [NUM_DIGITS-1:0]   blank_mask
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   // Registered copies of the bus, plus last cycle's copy for change detection.
   logic [6:0]            s_seg, p_seg;
   logic [NUM_DIGITS-1:0] s_sel, p_sel;
   logic                  chg;

   // Stability filter.
   logic [CW-1:0] cnt;
   logic          stable;

   // Digit-select decode.
   logic [NUM_DIGITS-1:0] low;
   logic                  sel_one;
   logic [IW-1:0]         sel_idx;

   // Glyph decode of the registered pattern.
   logic       g_hit, g_blank;
   logic [3:0] g_nib;

   // Frame capture state.
   state_e                     state, nstate;
   logic                       commit;
   logic [NUM_DIGITS-1:0][3:0] shadow;
   logic [NUM_DIGITS-1:0]      err, blk, seen;

   // Input stage. It resets to an idle bus: nothing lit, no digit selected.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_seg <= SEG_BLANK;
         s_sel <= '1;
         p_seg <= SEG_BLANK;
         p_sel <= '1;
      end else begin
         s_seg <= seg;
         s_sel <= dig_sel;
         p_seg <= s_seg;
         p_sel <= s_sel;
      end
   end

   assign chg = ({s_seg, s_sel} != {p_seg, p_sel});

   // Count identical registered samples. The count saturates, so a static
   // bus passes the stable point only once.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (chg)
         cnt <= '0;
      else if (cnt < CW'(STABLE_CYCLES))
         cnt <= cnt + 1'b1;
   end

   assign stable = (cnt == CW'(STABLE_CYCLES - 1));

   // A commit needs exactly one digit select low. Blanking (all high) and
   // overlapping selects are ignored.
   assign low = ~s_sel;

   always_comb begin
      sel_one = (low != '0) && ((low & (low - NUM_DIGITS'(1))) == '0);
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (low[i]) sel_idx = IW'(i);
   end

   seg7_glyph_decode u_dec (
      .pat    (s_seg),
      .hit    (g_hit),
      .blank  (g_blank),
      .nibble (g_nib)
   );

   // Next-state logic. Publishing takes priority over a commit, so the
   // frame being published and the clearing of seen never race with a
   // new capture.
   always_comb begin
      nstate = state;
      commit = 1'b0;
      unique case (state)
         ST_WAIT: begin
            if (&seen)
               nstate = ST_PUBLISH;
            else if (stable && sel_one) begin
               commit = 1'b1;
               nstate = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (&seen)
               nstate = ST_PUBLISH;
            else if (chg)
               nstate = ST_WAIT;
         end
         ST_PUBLISH: nstate = ST_WAIT;
         default:    nstate = ST_WAIT;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_WAIT;
      else
         state <= nstate;
   end

   // Per-digit shadow capture. A recommit overwrites that digit; seen only
   // accumulates until the frame is published.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
         err    <= '0;
         blk    <= '0;
         seen   <= '0;
      end else if (nstate == ST_PUBLISH) begin
         err  <= '0;
         blk  <= '0;
         seen <= '0;
      end else if (commit) begin
         shadow[sel_idx] <= g_nib;
         err[sel_idx]    <= !g_hit && !g_blank;
         blk[sel_idx]    <= g_blank;
         seen[sel_idx]   <= 1'b1;
      end
   end

   // Frame outputs load on entry to PUBLISH. value_valid is high only for
   // the PUBLISH cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         value       <= '0;
         value_valid <= 1'b0;
         digit_err   <= '0;
         blank_mask  <= '0;
      end else begin
         value_valid <= (nstate == ST_PUBLISH);
         if (nstate == ST_PUBLISH) begin
            value      <= shadow;
            digit_err  <= err;
            blank_mask <= blk;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder.
// Stimulus pushes the expected frame before driving the scan. A monitor
// pops that frame and compares it whenever value_valid pulses.
module tb_seg7_scan_decoder;

   localparam int ND = 8;
   localparam int SC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [6:0]      seg;
   logic [ND-1:0]   dig_sel;
   logic [4*ND-1:0] value;
   logic            value_valid;
   logic [ND-1:0]   digit_err, blank_mask;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] v;
      logic [7:0]  e;
      logic [7:0]  b;
      string       name;
   } exp_t;

   exp_t q[$];

   // Hand-copied active-low glyphs 0..F.
   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .value       (value),
      .value_valid (value_valid),
      .digit_err   (digit_err),
      .blank_mask  (blank_mask)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive digit k with pattern p for n cycles. Inputs change on the negedge.
   task automatic show(input int k, input logic [6:0] p, input int n);
      dig_sel = ~(ND'(1) << k);
      seg     = p;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: samples 2 time units after each posedge.
   always @(posedge clk) begin
      exp_t x;
      #2;
      if (!rst && value_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got value=%h expected no frame", value);
         end else begin
            x = q.pop_front();
            chk({x.name, "_value"}, value, x.v);
            chk({x.name, "_err"}, 32'(digit_err), 32'(x.e));
            chk({x.name, "_blank"}, 32'(blank_mask), 32'(x.b));
         end
      end
   end

   initial begin
      rst     = 1'b1;
      seg     = 7'h7F;
      dig_sel = '1;
      repeat (3) @(negedge clk);
      chk("rst_value", value, 32'h0);
      chk("rst_valid", 32'(value_valid), 32'h0);
      chk("rst_err", 32'(digit_err), 32'h0);
      chk("rst_blank", 32'(blank_mask), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Static scan: digit k shows 8-k.
      q.push_back('{32'h12345678, 8'h00, 8'h00, "scan"});
      for (int k = 0; k < ND; k++) show(k, glyph[8-k], 6);

      // Glitch: a 2-cycle 7'h00 inside digit 3's glyph A hold must not commit.
      q.push_back('{32'h1234A678, 8'h00, 8'h00, "glitch"});
      for (int k = 0; k < ND; k++) begin
         if (k == 3) begin
            show(3, glyph[10], 6);
            show(3, 7'h00, 2);
            show(3, glyph[10], 6);
         end else begin
            show(k, glyph[8-k], 6);
         end
      end

      // Blank and invalid patterns.
      q.push_back('{32'h00000000, 8'h40, 8'h20, "blankinv"});
      for (int k = 0; k < ND; k++)
         show(k, (k == 5) ? 7'h7F : (k == 6) ? 7'h7E : glyph[0], 6);

      // Static hold: one commit of digit 0 and no frame. The rest of the
      // digits then complete the frame around that single commit.
      show(0, glyph[15], 100);
      q.push_back('{32'h7654321F, 8'h00, 8'h00, "hold"});
      for (int k = 1; k < ND; k++) show(k, glyph[k], 6);

      // Select faults in mid-frame: blanking and two overlapping selects.
      q.push_back('{32'h99999999, 8'h00, 8'h00, "selfault"});
      show(0, glyph[9], 6);
      show(1, glyph[9], 6);
      dig_sel = 8'hFF; seg = glyph[0];
      repeat (10) @(negedge clk);
      dig_sel = 8'hFC;
      repeat (10) @(negedge clk);
      for (int k = 2; k < ND; k++) show(k, glyph[9], 6);

      // Reset mid-frame: the partial capture must be dropped.
      for (int k = 0; k < 5; k++) show(k, glyph[15-k], 6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_value", value, 32'h0);
      chk("midrst_valid", 32'(value_valid), 32'h0);
      q.push_back('{32'h76543210, 8'h00, 8'h00, "postrst"});
      for (int k = ND-1; k >= 0; k--) show(k, glyph[k], 6);

      // Wait for the last frame, with a cycle bound.
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d expected 0", q.size());
      end
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
